quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_pkg.sv | 45 ++++
 rtl/quad_sync_filter.sv | 55 +++++
 rtl/quad_decoder.sv | 109 ++++++++++
 tb/tb_quad_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared quadrature definitions: phase encodings and
// transition classification for decoder/encoder blocks.
package quad_pkg;

    typedef enum logic [1:0] {
        P00 = 2'b00,
        P01 = 2'b01,
        P11 = 2'b11,
        P10 = 2'b10
    } phase_t;

    typedef enum logic [1:0] {
        T_HOLD = 2'd0,
        T_FWD  = 2'd1,
        T_BWD  = 2'd2,
        T_ILL  = 2'd3
    } trans_t;

    localparam int FILT_MAX = 15;

    function automatic phase_t fwd_next(phase_t p);
        phase_t n;
        unique case (p)
            P00: n = P01;
            P01: n = P11;
            P11: n = P10;
            default: n = P00;
        endcase
        return n;
    endfunction

    function automatic trans_t classify(phase_t from, phase_t to);
        trans_t t;
        if (from == to)
            t = T_HOLD;
        else if (to == fwd_next(from))
            t = T_FWD;
        else if (from == fwd_next(to))
            t = T_BWD;
        else
            t = T_ILL;
        return t;
    endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Two-flop synchronizer plus run-length glitch filter for
// one quadrature phase; valid rises on the first accepted level.
module quad_sync_filter #(
    parameter int FILT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic valid
);

    localparam logic [3:0] CMAX = 4'(FILT);

    logic       s1, s2;
    logic       v1, v2;
    logic       cand;
    logic [3:0] cnt;
    logic       acc, acc_v;

    // v1/v2 mask the reset zeros still flushing out of s1/s2
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            cand  <= 1'b0;
            cnt   <= 4'd0;
            acc   <= 1'b0;
            acc_v <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            v1 <= 1'b1;
            v2 <= v1;
            if (v2) begin
                if (s2 != cand) begin
                    cand <= s2;
                    cnt  <= 4'd1;
                end else if (cnt != CMAX) begin
                    cnt <= cnt + 4'd1;
                end
            end
            if (cnt == CMAX) begin
                acc   <= cand;
                acc_v <= 1'b1;
            end
        end
    end

    assign dout  = acc;
    assign valid = acc_v;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phases drive a 4-state
// phase tracker and a modulo-2^N position counter.
module quad_decoder #(
    parameter int N    = 4,
    parameter int FILT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         enable,
    input  logic         clear,
    output logic [N-1:0] pos,
    output logic         dir,
    output logic         step,
    output logic         err
);

    import quad_pkg::*;

    logic a_f, a_v, b_f, b_v;

    quad_sync_filter #(.FILT(FILT)) u_sync_a (
        .clk   (clk),
        .reset (reset),
        .din   (a_in),
        .dout  (a_f),
        .valid (a_v)
    );

    quad_sync_filter #(.FILT(FILT)) u_sync_b (
        .clk   (clk),
        .reset (reset),
        .din   (b_in),
        .dout  (b_f),
        .valid (b_v)
    );

    phase_t       ab_f;
    trans_t       trans;
    phase_t       phase_q, phase_d;
    logic         init_q, init_d;
    logic [N-1:0] pos_q, pos_d;
    logic         dir_q, dir_d;
    logic         step_q, step_d;
    logic         err_q, err_d;

    assign ab_f  = phase_t'({a_f, b_f});
    assign trans = classify(phase_q, ab_f);

    always_comb begin
        phase_d = phase_q;
        init_d  = init_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q;
        if (a_v && b_v) begin
            phase_d = ab_f;
            init_d  = 1'b1;
            // first accepted value only seeds the phase
            if (init_q) begin
                unique case (trans)
                    T_FWD: if (enable) begin
                        pos_d  = pos_q + N'(1);
                        dir_d  = 1'b1;
                        step_d = 1'b1;
                    end
                    T_BWD: if (enable) begin
                        pos_d  = pos_q - N'(1);
                        dir_d  = 1'b0;
                        step_d = 1'b1;
                    end
                    T_ILL: err_d = 1'b1;
                    default: ;
                endcase
            end
        end
        if (clear) begin
            pos_d  = '0;
            err_d  = 1'b0;
            step_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= P00;
            init_q  <= 1'b0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            init_q  <= init_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign pos  = pos_q;
    assign dir  = dir_q;
    assign step = step_q;
    assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with a cycle-level
// reference model and hand-computed checkpoints.
module tb_quad_decoder;

    localparam int N    = 4;
    localparam int FILT = 2;
    localparam int MODV = 1 << N;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         a_in = 1'b0;
    logic         b_in = 1'b0;
    logic         enable = 1'b1;
    logic         clear = 1'b0;
    logic [N-1:0] pos;
    logic         dir, step, err;

    quad_decoder #(.N(N), .FILT(FILT)) dut (
        .clk    (clk),
        .reset  (reset),
        .a_in   (a_in),
        .b_in   (b_in),
        .enable (enable),
        .clear  (clear),
        .pos    (pos),
        .dir    (dir),
        .step   (step),
        .err    (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int nsteps = 0;

    // model: per-phase sample history, accepted levels, counter
    bit sa [0:31];
    bit sb [0:31];
    bit sv [0:31];
    bit acc_a, acc_b, ava, avb;
    bit m_init, m_dir, m_step, m_err;
    bit [1:0] m_ph;
    int m_pos;
    bit started = 0;

    function automatic int qidx(bit [1:0] v);
        case (v)
            2'b00: return 0;
            2'b01: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin
        bit okA, okB;
        bit [1:0] cur;
        int d;
        m_step = 0;
        if (reset) begin
            m_pos = 0; m_dir = 0; m_err = 0; m_init = 0;
            ava = 0; avb = 0; acc_a = 0; acc_b = 0;
            for (int i = 0; i < 32; i++) sv[i] = 0;
        end else begin
            if (ava && avb) begin
                cur = {acc_a, acc_b};
                if (!m_init) begin
                    m_ph = cur;
                    m_init = 1;
                end else if (cur != m_ph) begin
                    d = (qidx(cur) - qidx(m_ph) + 4) % 4;
                    if (d == 2) begin
                        m_err = 1;
                    end else if (enable) begin
                        m_pos = (d == 1) ? (m_pos + 1) % MODV
                                         : (m_pos + MODV - 1) % MODV;
                        m_dir = (d == 1);
                        m_step = 1;
                    end
                    m_ph = cur;
                end
            end
            if (clear) begin
                m_pos = 0; m_err = 0; m_step = 0;
            end
            // a level is accepted once FILT post-reset samples,
            // taken 3..FILT+2 edges ago, all agree
            okA = 1; okB = 1;
            for (int i = 2; i <= FILT + 1; i++) begin
                if (!sv[i] || sa[i] != sa[2]) okA = 0;
                if (!sv[i] || sb[i] != sb[2]) okB = 0;
            end
            if (okA) begin acc_a = sa[2]; ava = 1; end
            if (okB) begin acc_b = sb[2]; avb = 1; end
        end
        for (int i = 31; i > 0; i--) begin
            sa[i] = sa[i-1]; sb[i] = sb[i-1]; sv[i] = sv[i-1];
        end
        sa[0] = a_in; sb[0] = b_in; sv[0] = !reset;
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (int'(pos) != m_pos) begin
                failures++;
                $display("FAIL model_pos t=%0t got %0d exp %0d", $time, pos, m_pos);
            end
            checks++;
            if (dir != m_dir) begin
                failures++;
                $display("FAIL model_dir t=%0t got %0d exp %0d", $time, dir, m_dir);
            end
            checks++;
            if (step != m_step) begin
                failures++;
                $display("FAIL model_step t=%0t got %0d exp %0d", $time, step, m_step);
            end
            checks++;
            if (err != m_err) begin
                failures++;
                $display("FAIL model_err t=%0t got %0d exp %0d", $time, err, m_err);
            end
            if (step) nsteps++;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic hold(input bit [1:0] v, input int n);
        a_in = v[1];
        b_in = v[0];
        repeat (n) @(negedge clk);
    endtask

    int s0;

    initial begin
        @(negedge clk);
        reset = 1'b0;
        chk("reset_pos", int'(pos), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_step", int'(step), 0);

        hold(2'b00, 8);
        chk("init_pos", int'(pos), 0);
        s0 = nsteps;
        hold(2'b01, 8); chk("fwd_pos1", int'(pos), 1);
        hold(2'b11, 8); chk("fwd_pos2", int'(pos), 2);
        hold(2'b10, 8); chk("fwd_pos3", int'(pos), 3);
        hold(2'b00, 8); chk("fwd_pos4", int'(pos), 4);
        chk("fwd_dir", int'(dir), 1);
        chk("fwd_steps", nsteps - s0, 4);
        chk("fwd_err", int'(err), 0);

        clear = 1'b1; hold(2'b00, 1); clear = 1'b0;
        hold(2'b01, 8); chk("pre_rev_pos", int'(pos), 1);
        hold(2'b00, 8); chk("rev_pos0", int'(pos), 0);
        chk("rev_dir", int'(dir), 0);
        hold(2'b10, 8); chk("rev_wrap15", int'(pos), 15);
        hold(2'b11, 8); chk("rev_pos14", int'(pos), 14);
        chk("rev_dir2", int'(dir), 0);

        hold(2'b01, 8);
        hold(2'b00, 8); chk("pre_glitch", int'(pos), 12);
        s0 = nsteps;
        hold(2'b10, 1);
        hold(2'b00, 10);
        chk("glitch_pos", int'(pos), 12);
        chk("glitch_steps", nsteps - s0, 0);
        chk("glitch_err", int'(err), 0);

        hold(2'b11, 8);
        chk("jump_err", int'(err), 1);
        chk("jump_pos", int'(pos), 12);
        clear = 1'b1; hold(2'b11, 1); clear = 1'b0;
        hold(2'b11, 2);
        chk("clr_pos", int'(pos), 0);
        chk("clr_err", int'(err), 0);

        enable = 1'b0;
        s0 = nsteps;
        hold(2'b10, 8);
        hold(2'b00, 8);
        chk("dis_pos", int'(pos), 0);
        chk("dis_steps", nsteps - s0, 0);
        enable = 1'b1;
        hold(2'b01, 8);
        chk("en_pos", int'(pos), 1);

        hold(2'b11, 8);
        hold(2'b10, 8);
        chk("pre_rst_pos", int'(pos), 3);
        hold(2'b00, 2);
        reset = 1'b1;
        hold(2'b10, 1);
        reset = 1'b0;
        s0 = nsteps;
        hold(2'b10, 12);
        chk("rst_pos", int'(pos), 0);
        chk("rst_steps", nsteps - s0, 0);
        chk("rst_err", int'(err), 0);
        hold(2'b00, 8);
        chk("post_rst_pos", int'(pos), 1);
        chk("post_rst_dir", int'(dir), 1);

        clear = 1'b1;
        s0 = nsteps;
        hold(2'b01, 8);
        clear = 1'b0;
        chk("clr_step_pos", int'(pos), 0);
        chk("clr_step_steps", nsteps - s0, 0);
        hold(2'b11, 8);
        chk("after_clr_pos", int'(pos), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
